rgb_sequencer: RTL and testbench

- Drives the board RGB LED through a programmable colour sequence.
- Each colour step is a three-channel PWM duty triple, held for a programmable number of PWM periods.
- Sits between the top-level control and the LED pins, replacing direct counter-bit LED drive with sequenced, dimmable colour.
- Configuration is written through a simple register write port; sequencing is controlled by start, stop and pause pulses.

---
 rtl/rgb_sequencer_if.sv | 41 ++++
 rtl/rgb_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_rgb_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_sequencer_if.sv
// Control, configuration and LED-status bundle for the RGB LED sequencer.
// Ports: start/stop pulses, pause/loop levels, table write port (cfg_we/cfg_addr/cfg_data),
//        sequence shape (cfg_len/hold); returns led_r/g/b, step_idx, busy, done.
interface rgb_sequencer_if #(
    parameter int PWM_BITS  = 8,
    parameter int HOLD_BITS = 16,
    parameter int STEPS     = 8
);
    localparam int AW = $clog2(STEPS);

    // controller -> sequencer
    logic                    start;
    logic                    stop;
    logic                    pause;
    logic                    loop;
    logic                    cfg_we;
    logic [AW-1:0]           cfg_addr;
    logic [3*PWM_BITS-1:0]   cfg_data;
    logic [AW-1:0]           cfg_len;
    logic [HOLD_BITS-1:0]    hold;

    // sequencer -> controller / pins
    logic                    led_r;
    logic                    led_g;
    logic                    led_b;
    logic [AW-1:0]           step_idx;
    logic                    busy;
    logic                    done;

    modport master (
        output start, stop, pause, loop,
        output cfg_we, cfg_addr, cfg_data, cfg_len, hold,
        input  led_r, led_g, led_b, step_idx, busy, done
    );

    modport slave (
        input  start, stop, pause, loop,
        input  cfg_we, cfg_addr, cfg_data, cfg_len, hold,
        output led_r, led_g, led_b, step_idx, busy, done
    );
endinterface

// File: rtl/rgb_sequencer.sv
// Purpose: steps the RGB LED through a table of PWM duty triples, each held hold+1 PWM periods.
// Latency: LED pins are registered one clk after the PWM count they reflect; start takes effect next edge.
// Backpressure: none; table writes accepted every cycle, pause freezes all counters and outputs.
// Ports: clk, rst (sync, active-low), bus (rgb_sequencer_if.slave) carrying control, config and LED status.
module rgb_sequencer #(
    parameter int PWM_BITS  = 8,
    parameter int HOLD_BITS = 16,
    parameter int STEPS     = 8
) (
    input  logic               clk,
    input  logic               rst,
    rgb_sequencer_if.slave     bus
);
    localparam int AW = $clog2(STEPS);
    localparam int DW = 3 * PWM_BITS;
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Colour table and per-sequence latched configuration
    logic [DW-1:0]         table_q [STEPS];
    logic [AW-1:0]         len_lat;
    logic [HOLD_BITS-1:0]  hold_lat;

    // Running counters
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [HOLD_BITS-1:0]  hold_cnt;
    logic [AW-1:0]         step_q;

    // Duties in use for the current PWM period
    logic [PWM_BITS-1:0]   duty_r;
    logic [PWM_BITS-1:0]   duty_g;
    logic [PWM_BITS-1:0]   duty_b;

    // Registered outputs
    logic                  led_r_q;
    logic                  led_g_q;
    logic                  led_b_q;
    logic                  done_q;
    logic                  busy_c;

    // Decode of the current cycle
    logic                  active;
    logic                  do_start;
    logic                  advance;
    logic                  period_end;
    logic                  hold_more;
    logic                  step_more;
    logic                  step_end;
    logic                  seq_end;
    logic [AW-1:0]         step_nxt;
    logic [AW-1:0]         lat_idx;

    assign active     = (state == RUN) || (state == PAUSE);
    assign do_start   = (state == IDLE) && bus.start && !bus.stop;

    // The counters move on every active cycle with pause low. A cycle in RUN
    // that sees pause high is already frozen, and the PAUSE cycle that sees
    // pause low already counts, so N cycles of pause cost exactly N cycles.
    assign advance    = active && !bus.pause && !bus.stop;
    assign period_end = advance && (pwm_cnt == PWM_MAX);
    assign hold_more  = hold_cnt < hold_lat;
    assign step_more  = step_q < len_lat;
    assign step_end   = period_end && !hold_more;
    assign seq_end    = step_end && !step_more && !bus.loop;

    // Step that follows the current one at a step end (wraps to 0 after len)
    always_comb begin
        step_nxt = '0;
        if (step_more) begin
            step_nxt = step_q + 1'b1;
        end
    end

    // Table entry whose duties are loaded at a period boundary
    always_comb begin
        lat_idx = step_q;
        if (!hold_more) begin
            lat_idx = step_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. stop beats start and beats sequence completion.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (do_start) begin
                    state_nxt = RUN;
                end
            end
            RUN, PAUSE: begin
                if (bus.stop || seq_end) begin
                    state_nxt = IDLE;
                end else if (bus.pause) begin
                    state_nxt = PAUSE;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        busy_c = 1'b0;
        case (state)
            RUN, PAUSE: busy_c = 1'b1;
            default:    busy_c = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Colour table. A write and a boundary latch of the same entry in the
    // same cycle: the latch reads table_q before the write lands, so it
    // takes the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STEPS; i++) begin
                table_q[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            table_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing datapath: counters, latched config/duties, LED drive
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt  <= '0;
            hold_cnt <= '0;
            step_q   <= '0;
            len_lat  <= '0;
            hold_lat <= '0;
            duty_r   <= '0;
            duty_g   <= '0;
            duty_b   <= '0;
            led_r_q  <= 1'b0;
            led_g_q  <= 1'b0;
            led_b_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= seq_end;

            if (state_nxt == IDLE) begin
                // Idle, stop, or completion: park everything at 0
                pwm_cnt  <= '0;
                hold_cnt <= '0;
                step_q   <= '0;
                led_r_q  <= 1'b0;
                led_g_q  <= 1'b0;
                led_b_q  <= 1'b0;
            end else if (do_start) begin
                pwm_cnt  <= '0;
                hold_cnt <= '0;
                step_q   <= '0;
                len_lat  <= bus.cfg_len;
                hold_lat <= bus.hold;
                {duty_r, duty_g, duty_b} <= table_q[0];
            end else if (advance) begin
                // LED reflects the count of this cycle, visible next cycle
                led_r_q <= pwm_cnt < duty_r;
                led_g_q <= pwm_cnt < duty_g;
                led_b_q <= pwm_cnt < duty_b;
                pwm_cnt <= pwm_cnt + 1'b1;

                if (period_end) begin
                    if (hold_more) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        hold_cnt <= '0;
                        step_q   <= step_nxt;
                        // Only a looping wrap reaches here past the last
                        // step; a non-loop end goes IDLE above.
                        if (!step_more) begin
                            len_lat  <= bus.cfg_len;
                            hold_lat <= bus.hold;
                        end
                    end
                    // Duties only ever change on a period start
                    {duty_r, duty_g, duty_b} <= table_q[lat_idx];
                end
            end
        end
    end

    assign bus.led_r    = led_r_q;
    assign bus.led_g    = led_g_q;
    assign bus.led_b    = led_b_q;
    assign bus.step_idx = step_q;
    assign bus.busy     = busy_c;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_rgb_sequencer.sv
module tb_rgb_sequencer;
    localparam int PWM_BITS  = 4;
    localparam int HOLD_BITS = 4;
    localparam int STEPS     = 8;
    localparam int AW        = 3;
    localparam int DW        = 12;
    localparam int PER       = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rgb_sequencer_if #(.PWM_BITS(PWM_BITS), .HOLD_BITS(HOLD_BITS), .STEPS(STEPS)) bus ();

    rgb_sequencer #(.PWM_BITS(PWM_BITS), .HOLD_BITS(HOLD_BITS), .STEPS(STEPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // ---------------- reference model: time-based view of the sequence ----
    // m_t counts active (unpaused) cycles since the current pass started;
    // step and PWM phase follow from it arithmetically.
    bit            m_valid = 0;
    bit            m_act;
    int            m_t, m_len, m_hold, m_step;
    logic [DW-1:0] m_tab [STEPS];
    logic [DW-1:0] m_duty;
    bit            m_r, m_g, m_b, m_done;

    task automatic model_edge();
        int pwm;
        int per_step;
        if (!rst) begin
            m_valid = 1; m_act = 0; m_t = 0; m_len = 0; m_hold = 0; m_step = 0;
            m_duty = '0; m_r = 0; m_g = 0; m_b = 0; m_done = 0;
            for (int i = 0; i < STEPS; i++) m_tab[i] = '0;
            return;
        end
        m_done = 0;
        if (m_act) begin
            if (bus.stop) begin
                m_act = 0; m_r = 0; m_g = 0; m_b = 0; m_step = 0;
            end else if (!bus.pause) begin
                pwm = m_t % PER;
                m_r = pwm < int'(m_duty[11:8]);
                m_g = pwm < int'(m_duty[7:4]);
                m_b = pwm < int'(m_duty[3:0]);
                m_t++;
                per_step = PER * (m_hold + 1);
                if (m_t == per_step * (m_len + 1)) begin
                    if (bus.loop) begin
                        m_t = 0; m_len = int'(bus.cfg_len); m_hold = int'(bus.hold);
                    end else begin
                        m_act = 0; m_done = 1; m_r = 0; m_g = 0; m_b = 0; m_step = 0;
                    end
                end
                if (m_act) begin
                    m_step = m_t / (PER * (m_hold + 1));
                    if (m_t % PER == 0) m_duty = m_tab[m_step];
                end
            end
        end else if (bus.start && !bus.stop) begin
            m_act = 1; m_t = 0; m_step = 0;
            m_len = int'(bus.cfg_len); m_hold = int'(bus.hold);
            m_duty = m_tab[0];
        end
        if (bus.cfg_we) m_tab[bus.cfg_addr] = bus.cfg_data;
    endtask

    task automatic tick();
        logic [7:0] got, exp;
        logic [2:0] ms;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        if (m_valid) begin
            ms  = m_step[2:0];
            exp = {m_r, m_g, m_b, ms, m_act, m_done};
            got = {bus.led_r, bus.led_g, bus.led_b, bus.step_idx, bus.busy, bus.done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model cyc=%0d {rgb,step,busy,done} got=%b required=%b", cyc, got, exp);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cfg_we = 1; bus.cfg_addr = a; bus.cfg_data = d;
        tick();
        bus.cfg_we = 0;
    endtask

    task automatic start_seq(input int len, input int hl, input bit lp);
        bus.cfg_len = AW'(len); bus.hold = HOLD_BITS'(hl); bus.loop = lp;
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    task automatic stop_seq();
        bus.stop = 1;
        tick();
        bus.stop = 0;
    endtask

    // ---------------- table-driven vectors ---------------------------------
    typedef struct {
        bit            rst;
        bit            start;
        bit            stop;
        bit            we;
        logic [DW-1:0] data;
        bit            e_busy;
        logic [2:0]    e_step;
        bit            e_done;
        logic [2:0]    e_led;
    } vec_t;

    vec_t vt [8];

    function automatic vec_t mk(bit r, bit st, bit sp, bit we, logic [DW-1:0] d,
                                bit eb, bit ed, logic [2:0] el);
        vec_t v;
        v.rst = r; v.start = st; v.stop = sp; v.we = we; v.data = d;
        v.e_busy = eb; v.e_step = 3'd0; v.e_done = ed; v.e_led = el;
        return v;
    endfunction

    initial begin
        int rc, gc, bc, gfirst, bad;
        int t1, t2, td, tw, nd;
        logic [5:0] snap;

        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.loop = 1;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.cfg_len = '0; bus.hold = '0;

        // Entry 0 = {15,8,0}; len=0, hold=0, loop=1 throughout the table
        vt[0] = mk(0, 0, 0, 0, 12'h000, 0, 0, 3'b000); // reset
        vt[1] = mk(1, 0, 0, 1, 12'hF80, 0, 0, 3'b000); // write entry 0
        vt[2] = mk(1, 1, 1, 0, 12'h000, 0, 0, 3'b000); // start+stop: stop wins
        vt[3] = mk(1, 1, 0, 0, 12'h000, 1, 0, 3'b000); // start; LEDs not yet driven
        vt[4] = mk(1, 0, 0, 0, 12'h000, 1, 0, 3'b110); // pwm 0
        vt[5] = mk(1, 0, 0, 0, 12'h000, 1, 0, 3'b110); // pwm 1
        vt[6] = mk(1, 0, 1, 0, 12'h000, 0, 0, 3'b000); // stop in RUN: off, no done
        vt[7] = mk(1, 1, 0, 0, 12'h000, 1, 0, 3'b000); // restart

        foreach (vt[i]) begin
            rst = vt[i].rst; bus.start = vt[i].start; bus.stop = vt[i].stop;
            bus.cfg_we = vt[i].we; bus.cfg_data = vt[i].data; bus.cfg_addr = '0;
            tick();
            chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vt[i].e_busy));
            chk($sformatf("vec%0d_done", i), int'(bus.done), int'(vt[i].e_done));
            chk($sformatf("vec%0d_step", i), int'(bus.step_idx), int'(vt[i].e_step));
            chk($sformatf("vec%0d_led", i), int'({bus.led_r, bus.led_g, bus.led_b}), int'(vt[i].e_led));
        end
        bus.start = 0; bus.stop = 0; bus.cfg_we = 0;

        // Scenario 1: one full period after restart
        rc = 0; gc = 0; bc = 0; gfirst = -1; bad = 0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            rc += int'(bus.led_r); gc += int'(bus.led_g); bc += int'(bus.led_b);
            if (bus.led_g && gfirst < 0) gfirst = n;
            if (!bus.busy) bad++;
        end
        chk("s1_red_high", rc, 15);
        chk("s1_green_high", gc, 8);
        chk("s1_blue_high", bc, 0);
        chk("s1_green_first", gfirst, 1);
        chk("s1_busy_low_cycles", bad, 0);
        stop_seq();

        // Scenario 2: three steps, hold=1, no loop
        wr(3'd0, 12'h123); wr(3'd1, 12'h456); wr(3'd2, 12'h9AF);
        start_seq(2, 1, 0);
        t1 = -1; t2 = -1; td = -1; nd = 0;
        for (int n = 1; n <= 120; n++) begin
            tick();
            if (bus.step_idx == 3'd1 && t1 < 0) t1 = n;
            if (bus.step_idx == 3'd2 && t2 < 0) t2 = n;
            if (bus.done) begin
                nd++;
                if (td < 0) begin
                    td = n;
                    chk("s2_busy_at_done", int'(bus.busy), 0);
                    chk("s2_led_at_done", int'({bus.led_r, bus.led_g, bus.led_b}), 0);
                end
            end
        end
        chk("s2_step1_at", t1, 32);
        chk("s2_step2_at", t2, 64);
        chk("s2_done_at", td, 96);
        chk("s2_done_count", nd, 1);

        // Scenario 3: same with loop=1
        start_seq(2, 1, 1);
        tw = -1; nd = 0; t2 = -1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (bus.step_idx == 3'd2 && t2 < 0) t2 = n;
            if (t2 > 0 && tw < 0 && bus.step_idx == 3'd0) begin
                tw = n;
                chk("s3_busy_at_wrap", int'(bus.busy), 1);
            end
            if (bus.done) nd++;
        end
        chk("s3_wrap_at", tw, 96);
        chk("s3_done_count", nd, 0);
        stop_seq();

        // Scenario 4: 10-cycle pause mid-step
        start_seq(2, 1, 0);
        repeat (10) tick();
        snap = {bus.led_r, bus.led_g, bus.led_b, bus.step_idx};
        bus.pause = 1;
        bad = 0;
        repeat (10) begin
            tick();
            if ({bus.led_r, bus.led_g, bus.led_b, bus.step_idx} !== snap || !bus.busy) bad++;
        end
        bus.pause = 0;
        chk("s4_frozen_violations", bad, 0);
        t1 = -1;
        for (int n = 21; n <= 60; n++) begin
            tick();
            if (bus.step_idx == 3'd1 && t1 < 0) t1 = n;
        end
        chk("s4_step1_at", t1, 42);
        stop_seq();

        // Scenario 6: rewrite the live entry mid-period, then reset mid-step
        wr(3'd0, 12'h400);
        start_seq(0, 0, 1);
        repeat (5) tick();
        wr(3'd0, 12'hC00);
        rc = 0;
        repeat (10) begin tick(); rc += int'(bus.led_r); end
        chk("s6_old_duty_rest_of_period", rc, 0);
        rc = 0;
        repeat (12) begin tick(); rc += int'(bus.led_r); end
        chk("s6_new_duty_next_period", rc, 12);
        repeat (3) tick();
        rst = 0;
        tick();
        chk("s6_rst_outputs", int'({bus.led_r, bus.led_g, bus.led_b, bus.step_idx, bus.busy, bus.done}), 0);
        rst = 1;
        tick();
        chk("s6_idle_after_rst", int'(bus.busy), 0);
        start_seq(0, 0, 1);
        rc = 0;
        repeat (16) begin tick(); rc += int'(bus.led_r) + int'(bus.led_g) + int'(bus.led_b); end
        chk("s6_table_cleared", rc, 0);
        stop_seq();

        // Randomized phase against the model
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 599) != 0);
            bus.start  = ($urandom_range(0, 7) == 0);
            bus.stop   = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 15) == 0) bus.pause = ~bus.pause;
            if ($urandom_range(0, 31) == 0) bus.loop = $urandom_range(0, 1);
            bus.cfg_we   = ($urandom_range(0, 3) == 0);
            bus.cfg_addr = AW'($urandom_range(0, STEPS - 1));
            bus.cfg_data = DW'($urandom);
            bus.cfg_len  = AW'($urandom_range(0, STEPS - 1));
            bus.hold     = HOLD_BITS'($urandom_range(0, 2));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
